// File: rtl/pll_pkg.sv
// Shared constants, quadrant encoding and sine ROM entry function for the pll NCO.
package pll_pkg;

    localparam int unsigned ACC_W_DEFAULT  = 24;
    localparam int unsigned LUT_AW_DEFAULT = 6;
    localparam int unsigned SAMPLE_W       = 8;
    localparam int unsigned MAG_W          = SAMPLE_W - 1;

    localparam logic [ACC_W_DEFAULT-1:0] FCW_RST_DEFAULT = 24'h010000;

    // Quadrant taken from the two phase MSBs.
    typedef enum logic [1:0] {
        QuadI   = 2'd0,
        QuadII  = 2'd1,
        QuadIII = 2'd2,
        QuadIV  = 2'd3
    } quad_e;

    // Entry k of an n-entry quarter-wave table: round(127*sin(pi/2*(k+0.5)/n)).
    // Evaluated only at elaboration, so a Taylor series in real arithmetic is fine.
    function automatic logic [MAG_W-1:0] lut_entry(int k, int n);
        real x;
        real term;
        real s;
        x    = 1.5707963267948966 * (real'(k) + 0.5) / real'(n);
        term = x;
        s    = x;
        for (int i = 1; i < 10; i++) begin
            term = -term * x * x / real'((2 * i) * (2 * i + 1));
            s    = s + term;
        end
        return MAG_W'($rtoi(127.0 * s + 0.5));
    endfunction

endpackage

// File: rtl/pll_nco_if.sv
// Sample stream from the NCO to the pll stage: data/valid forward, ready backward.
interface pll_nco_if
    import pll_pkg::*;
();

    logic signed [SAMPLE_W-1:0] o_data;
    logic                       o_valid;
    logic                       i_ready;

    modport master (
        output o_data,
        output o_valid,
        input  i_ready
    );

    modport slave (
        input  o_data,
        input  o_valid,
        output i_ready
    );

endinterface

// File: rtl/nco_sine_lut.sv
// Registered quarter-wave sine ROM; holds its output while i_en is low.
module nco_sine_lut
    import pll_pkg::*;
#(
    parameter int unsigned LUT_AW = LUT_AW_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_en,
    input  logic [LUT_AW-1:0] i_addr,
    output logic [MAG_W-1:0]  o_mag
);

    localparam int N = 1 << LUT_AW;

    logic [MAG_W-1:0] rom [N];

    for (genvar k = 0; k < N; k++) begin : g_rom
        localparam logic [MAG_W-1:0] Entry = lut_entry(k, N);
        assign rom[k] = Entry;
    end

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            o_mag <= rom[i_addr];
        end
    end

endmodule

// File: rtl/pll_nco.sv
// Numerically controlled oscillator: phase accumulator, quarter-wave fold, ROM and sign stage
// behind a valid/ready output that stalls the whole pipeline under backpressure.
module pll_nco
    import pll_pkg::*;
#(
    parameter int unsigned       ACC_W   = ACC_W_DEFAULT,
    parameter int unsigned       LUT_AW  = LUT_AW_DEFAULT,
    parameter logic [ACC_W-1:0]  FCW_RST = ACC_W'(FCW_RST_DEFAULT)
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_enable,
    input  logic             i_fcw_valid,
    input  logic [ACC_W-1:0] i_fcw,
    input  logic             i_phase_clr,
    pll_nco_if.master        smp
);

    // Only the quadrant and LUT index bits of the phase travel down the pipe.
    localparam int unsigned PH_W = 2 + LUT_AW;

    logic                       stall;
    logic                       adv;

    logic [ACC_W-1:0]           acc_q, acc_d;
    logic [ACC_W-1:0]           fcw_q, fcw_d;

    logic                       s1_valid_q;
    logic [PH_W-1:0]            s1_phase_q;
    quad_e                      s1_quad;
    logic [LUT_AW-1:0]          s1_idx;
    logic [LUT_AW-1:0]          lut_addr;

    logic                       s2_valid_q;
    logic                       s2_neg_q;
    logic [MAG_W-1:0]           s2_mag;
    logic signed [SAMPLE_W-1:0] s2_mag_s;
    logic signed [SAMPLE_W-1:0] data_d;

    logic                       o_valid_q;
    logic signed [SAMPLE_W-1:0] o_data_q;

    assign stall = o_valid_q & ~smp.i_ready;
    assign adv   = i_enable & ~stall;

    // Clear wins over the increment; a sample captured this cycle still sees the old phase.
    always_comb begin
        acc_d = acc_q;
        fcw_d = fcw_q;
        if (i_phase_clr) begin
            acc_d = '0;
        end else if (adv) begin
            acc_d = acc_q + fcw_q;
        end
        if (i_fcw_valid) begin
            fcw_d = i_fcw;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            acc_q <= '0;
            fcw_q <= FCW_RST;
        end else begin
            acc_q <= acc_d;
            fcw_q <= fcw_d;
        end
    end

    assign s1_quad  = quad_e'(s1_phase_q[PH_W-1 -: 2]);
    assign s1_idx   = s1_phase_q[LUT_AW-1:0];
    assign lut_addr = (s1_quad inside {QuadII, QuadIV}) ? ~s1_idx : s1_idx;

    nco_sine_lut #(
        .LUT_AW (LUT_AW)
    ) u_lut (
        .i_clk  (i_clk),
        .i_en   (~stall),
        .i_addr (lut_addr),
        .o_mag  (s2_mag)
    );

    // Table entries never exceed 127, so the negate cannot overflow.
    assign s2_mag_s = {1'b0, s2_mag};
    assign data_d   = s2_neg_q ? -s2_mag_s : s2_mag_s;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s1_valid_q <= 1'b0;
            s1_phase_q <= '0;
            s2_valid_q <= 1'b0;
            s2_neg_q   <= 1'b0;
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
        end else if (!stall) begin
            s1_valid_q <= i_enable;
            if (adv) begin
                s1_phase_q <= acc_q[ACC_W-1 -: PH_W];
            end
            s2_valid_q <= s1_valid_q;
            s2_neg_q   <= (s1_quad inside {QuadIII, QuadIV});
            o_valid_q  <= s2_valid_q;
            if (s2_valid_q) begin
                o_data_q <= data_d;
            end
        end
    end

    assign smp.o_valid = o_valid_q;
    assign smp.o_data  = o_data_q;

endmodule

// File: tb/tb_pll_nco.sv
// Self-checking bench for pll_nco: scoreboard of spec-derived sine samples plus directed checks.
module tb_pll_nco;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b1;
    logic        i_enable = 1'b0;
    logic        i_fcw_valid = 1'b0;
    logic [23:0] i_fcw = '0;
    logic        i_phase_clr = 1'b0;

    pll_nco_if smp ();

    pll_nco u_dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_enable    (i_enable),
        .i_fcw_valid (i_fcw_valid),
        .i_fcw       (i_fcw),
        .i_phase_clr (i_phase_clr),
        .smp         (smp)
    );

    always #5 i_clk = ~i_clk;

    int          checks = 0;
    int          errors = 0;
    int          sb_q[$];
    int          adv_cnt = 0;
    int          acc_cnt = 0;
    logic [23:0] m_acc = '0;
    logic [23:0] m_fcw = 24'h010000;
    bit          was_stall = 1'b0;
    int          held_data = 0;

    task automatic check_eq(string tag, int got, int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: top 8 phase bits give quadrant and index; mirror in odd quadrants, negate in 3/4.
    function automatic int model_sample(logic [23:0] ph);
        int top;
        int q;
        int k;
        int mag;
        top = int'(ph[23:16]);
        q   = top >> 6;
        k   = top & 63;
        if (q == 1 || q == 3) k = 63 - k;
        mag = $rtoi(127.0 * $sin(3.14159265358979 * (real'(k) + 0.5) / 128.0) + 0.5);
        return (q >= 2) ? -mag : mag;
    endfunction

    // Called between negedge and posedge with inputs already set; returns at the next negedge.
    task automatic tick();
        bit stall;
        bit adv;
        if (was_stall) begin
            check_eq("hold_data", int'(smp.o_data), held_data);
            check_eq("hold_valid", int'(smp.o_valid), 1);
        end
        if (smp.o_valid && smp.i_ready) begin
            check_eq("sb_nonempty", int'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) check_eq("sample", int'(smp.o_data), sb_q.pop_front());
            acc_cnt++;
        end
        stall     = smp.o_valid && !smp.i_ready;
        adv       = i_enable && !stall;
        was_stall = stall;
        held_data = int'(smp.o_data);
        if (adv) begin
            sb_q.push_back(model_sample(m_acc));
            adv_cnt++;
        end
        if (i_phase_clr) m_acc = '0;
        else if (adv) m_acc = m_acc + m_fcw;
        if (i_fcw_valid) m_fcw = i_fcw;
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_enable    = 1'b0;
        i_fcw_valid = 1'b0;
        i_phase_clr = 1'b0;
        smp.i_ready = 1'b1;
        i_reset_n   = 1'b0;
        #1;
        check_eq("rst_valid", int'(smp.o_valid), 0);
        check_eq("rst_data", int'(smp.o_data), 0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        m_acc     = '0;
        m_fcw     = 24'h010000;
        adv_cnt   = adv_cnt - sb_q.size();
        sb_q.delete();
        was_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("post_rst_valid", int'(smp.o_valid), 0);
            check_eq("post_rst_data", int'(smp.o_data), 0);
            tick();
        end
    endtask

    int quad_tbl [4] = '{2, 127, -2, -127};
    int lat;

    initial begin
        smp.i_ready = 1'b1;
        #2;
        @(negedge i_clk);
        do_reset();

        // Quarter-period FCW: +2, +127, -2, -127 after a three-cycle latency.
        i_fcw_valid = 1'b1;
        i_fcw       = 24'h400000;
        tick();
        i_fcw_valid = 1'b0;
        i_enable    = 1'b1;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (smp.o_valid) begin
                lat = n;
                break;
            end
        end
        check_eq("latency", lat, 3);
        for (int j = 0; j < 12; j++) begin
            check_eq("quad_data", int'(smp.o_data), quad_tbl[j % 4]);
            check_eq("quad_valid", int'(smp.o_valid), 1);
            tick();
        end

        // Backpressure for five cycles.
        smp.i_ready = 1'b0;
        repeat (5) tick();
        smp.i_ready = 1'b1;
        repeat (8) tick();

        // FCW change concurrent with an advance.
        i_fcw_valid = 1'b1;
        i_fcw       = 24'h200000;
        tick();
        i_fcw_valid = 1'b0;
        repeat (10) tick();

        // Phase clear at acc = 0x7FFFFF.
        i_enable    = 1'b0;
        i_phase_clr = 1'b1;
        i_fcw_valid = 1'b1;
        i_fcw       = 24'h7FFFFF;
        tick();
        i_phase_clr = 1'b0;
        i_fcw_valid = 1'b0;
        i_enable    = 1'b1;
        tick();
        i_phase_clr = 1'b1;
        tick();
        i_phase_clr = 1'b0;
        repeat (8) tick();

        // Reset with the pipeline full.
        do_reset();

        // Random enable/ready/FCW loads.
        for (int c = 0; c < 10000; c++) begin
            i_enable    = ($urandom_range(0, 3) != 0);
            smp.i_ready = ($urandom_range(0, 3) != 0);
            i_fcw_valid = ($urandom_range(0, 15) == 0);
            i_fcw       = 24'($urandom);
            tick();
        end

        i_enable    = 1'b0;
        i_fcw_valid = 1'b0;
        smp.i_ready = 1'b1;
        repeat (10) tick();
        check_eq("drain_empty", sb_q.size(), 0);
        check_eq("accepted_vs_adv", acc_cnt, adv_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=%0d exp=%0d", checks, -1);
        $fatal(1, "timeout");
    end

endmodule
